// File: rtl/control_unit.sv
// Moore control FSM for the 16-bit accumulator-less datapath: sequences fetch,
// decode and execute of Load/Store/Add/Sub/Halt/NoOp instructions from IR.
module control_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] IR,
    output logic        PC_clr,
    output logic        PC_up,
    output logic        IR_ld,
    output logic [7:0]  D_addr,
    output logic        D_wr,
    output logic        RF_s,
    output logic [3:0]  RF_W_addr,
    output logic        RF_W_en,
    output logic [3:0]  RF_Ra_addr,
    output logic [3:0]  RF_Rb_addr,
    output logic [2:0]  ALU_s0,
    output logic [3:0]  OutState,
    output logic [3:0]  NextState
);

    typedef enum logic [3:0] {
        INIT   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        LOADA  = 4'd3,
        LOADB  = 4'd4,
        STORE  = 4'd5,
        ADD    = 4'd6,
        SUB    = 4'd7,
        HALT   = 4'd8,
        NOOP   = 4'd9
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;

    state_t state;
    state_t next_state;

    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // pre-edge values; the reset branch is asynchronous and overrides Clk.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        PC_clr     = 1'b0;
        PC_up      = 1'b0;
        IR_ld      = 1'b0;
        D_addr     = 8'h00;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = 4'h0;
        RF_W_en    = 1'b0;
        RF_Ra_addr = 4'h0;
        RF_Rb_addr = 4'h0;
        ALU_s0     = 3'd0;

        unique case (state)
            INIT: begin
                PC_clr     = 1'b1;
                next_state = FETCH;
            end
            FETCH: begin
                IR_ld      = 1'b1;
                PC_up      = 1'b1;
                next_state = DECODE;
            end
            DECODE: begin
                case (IR[15:12])
                    4'd1:    next_state = STORE;
                    4'd2:    next_state = LOADA;
                    4'd3:    next_state = ADD;
                    4'd4:    next_state = SUB;
                    4'd5:    next_state = HALT;
                    default: next_state = NOOP;
                endcase
            end
            LOADA: begin
                // Address is held for the synchronous memory read; the write lands in LoadB.
                D_addr     = IR[7:0];
                RF_s       = 1'b1;
                RF_W_addr  = IR[11:8];
                next_state = LOADB;
            end
            LOADB: begin
                D_addr     = IR[7:0];
                RF_s       = 1'b1;
                RF_W_addr  = IR[11:8];
                RF_W_en    = 1'b1;
                next_state = FETCH;
            end
            STORE: begin
                D_addr     = IR[7:0];
                RF_Ra_addr = IR[11:8];
                D_wr       = 1'b1;
                next_state = FETCH;
            end
            ADD, SUB: begin
                RF_Ra_addr = IR[11:8];
                RF_Rb_addr = IR[7:4];
                RF_W_addr  = IR[3:0];
                RF_W_en    = 1'b1;
                ALU_s0     = (state == ADD) ? ALU_ADD : ALU_SUB;
                next_state = FETCH;
            end
            HALT: begin
                next_state = HALT;
            end
            NOOP: begin
                next_state = FETCH;
            end
            default: begin
                next_state = INIT;
            end
        endcase
    end

    assign OutState  = state;
    assign NextState = next_state;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed and random instructions are
// expanded into expected state sequences and compared cycle by cycle.
module tb_control_unit;

    logic        Clk;
    logic        Reset;
    logic [15:0] IR;
    logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en;
    logic [7:0]  D_addr;
    logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, OutState, NextState;
    logic [2:0]  ALU_s0;

    typedef struct packed {
        logic       pc_clr;
        logic       pc_up;
        logic       ir_ld;
        logic [7:0] d_addr;
        logic       d_wr;
        logic       rf_s;
        logic [3:0] w_addr;
        logic       w_en;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] alu;
    } strobes_t;

    int checks = 0;
    int passed = 0;

    control_unit dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .IR         (IR),
        .PC_clr     (PC_clr),
        .PC_up      (PC_up),
        .IR_ld      (IR_ld),
        .D_addr     (D_addr),
        .D_wr       (D_wr),
        .RF_s       (RF_s),
        .RF_W_addr  (RF_W_addr),
        .RF_W_en    (RF_W_en),
        .RF_Ra_addr (RF_Ra_addr),
        .RF_Rb_addr (RF_Rb_addr),
        .ALU_s0     (ALU_s0),
        .OutState   (OutState),
        .NextState  (NextState)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Strobes each state must show, written straight from the state descriptions.
    function automatic strobes_t expect_strobes(input int st, input logic [15:0] ir);
        strobes_t s;
        s = '0;
        case (st)
            0: s.pc_clr = 1'b1;
            1: begin s.ir_ld = 1'b1; s.pc_up = 1'b1; end
            3: begin s.d_addr = ir[7:0]; s.rf_s = 1'b1; s.w_addr = ir[11:8]; end
            4: begin s.d_addr = ir[7:0]; s.rf_s = 1'b1; s.w_addr = ir[11:8]; s.w_en = 1'b1; end
            5: begin s.d_addr = ir[7:0]; s.ra = ir[11:8]; s.d_wr = 1'b1; end
            6, 7: begin
                s.ra = ir[11:8]; s.rb = ir[7:4]; s.w_addr = ir[3:0]; s.w_en = 1'b1;
                s.alu = (st == 6) ? 3'd1 : 3'd2;
            end
            default: s = '0;
        endcase
        return s;
    endfunction

    task automatic check_cycle(input int exp_state, input int exp_next, input logic [15:0] ir);
        strobes_t act;
        act = '{PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
                RF_Ra_addr, RF_Rb_addr, ALU_s0};
        check("OutState", 32'(OutState), 32'(exp_state));
        check("NextState", 32'(NextState), 32'(exp_next));
        check("strobes", 32'(act), 32'(expect_strobes(exp_state, ir)));
        check("wr_exclusive", 32'(D_wr & RF_W_en), 32'd0);
        check("pc_exclusive", 32'(PC_clr & PC_up), 32'd0);
    endtask

    // Expected state trace of one instruction, Fetch through its last cycle.
    function automatic void build_trace(input logic [15:0] ir, output int q[$]);
        q = {1, 2};
        case (int'(ir[15:12]))
            1: q.push_back(5);
            2: begin q.push_back(3); q.push_back(4); end
            3: q.push_back(6);
            4: q.push_back(7);
            5: q.push_back(8);
            default: q.push_back(9);
        endcase
    endfunction

    // Called one step after the edge that entered Fetch; returns likewise.
    task automatic run_instr(input logic [15:0] ir);
        int q[$];
        int nxt;
        build_trace(ir, q);
        IR = ir;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge Clk);
            if (i == q.size() - 1) nxt = 1;
            else nxt = q[i+1];
            check_cycle(q[i], nxt, ir);
            @(posedge Clk);
            #1;
        end
        check("latency", 32'(q.size()), (ir[15:12] == 4'd2) ? 32'd4 : 32'd3);
    endtask

    task automatic release_reset();
        #2 Reset = 1'b1;
        #1 check_cycle(0, 1, IR);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [15:0] rir;
        logic [3:0]  op;
        Reset = 1'b0;
        IR    = 16'h0000;

        repeat (3) begin
            @(negedge Clk);
            check_cycle(0, 1, IR);
        end
        release_reset();

        run_instr(16'h2A1F);
        run_instr(16'h3123);
        run_instr(16'h4123);
        run_instr(16'h1B05);
        run_instr(16'hF000);
        run_instr(16'h0000);

        for (int n = 0; n < 40; n++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'd5) op = 4'd6;
            rir = {op, 12'($urandom)};
            run_instr(rir);
        end

        // Reset dropped between edges while a load is in its read cycle.
        IR = 16'h2A1F;
        @(negedge Clk); check_cycle(1, 2, IR);
        @(posedge Clk); #1;
        @(negedge Clk); check_cycle(2, 3, IR);
        @(posedge Clk); #1;
        @(negedge Clk); check_cycle(3, 4, IR);
        #2 Reset = 1'b0;
        #1 check_cycle(0, 1, IR);
        repeat (3) begin
            @(negedge Clk);
            check_cycle(0, 1, IR);
        end
        release_reset();
        run_instr(16'h3456);

        // Halt holds with all strobes idle until reset.
        IR = 16'h5000;
        @(negedge Clk); check_cycle(1, 2, IR);
        @(posedge Clk); #1;
        @(negedge Clk); check_cycle(2, 8, IR);
        @(posedge Clk); #1;
        repeat (22) begin
            @(negedge Clk);
            check_cycle(8, 8, IR);
            @(posedge Clk); #1;
        end
        @(negedge Clk);
        #2 Reset = 1'b0;
        #1 check_cycle(0, 1, IR);
        @(negedge Clk); check_cycle(0, 1, IR);
        release_reset();
        run_instr(16'h2C07);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
